// File: rtl/multi_timer_pkg.sv
// multi_timer_pkg: register map, TCONF bit positions and per-channel write-enable bundle
package multi_timer_pkg;
  localparam logic [3:0] TMR_OFS   = 4'h0;
  localparam logic [3:0] TVAL_OFS  = 4'h4;
  localparam logic [3:0] TCONF_OFS = 4'h8;
  localparam logic [3:0] TSTAT_OFS = 4'hC;
  localparam int DIR_B     = 0;
  localparam int RUN_B     = 1;
  localparam int ONESHOT_B = 2;
  localparam int IE_B      = 3;
  localparam int PSC_LSB   = 8;
  localparam int PSC_MSB   = 15;
  localparam int CH_LSB    = 4;
  localparam int CH_MSB    = 11;
  typedef struct packed {
    logic tmr;
    logic tval;
    logic conf;
    logic stat;
  } ch_we_t;
endpackage

// File: rtl/multi_timer_if.sv
// multi_timer_if: 13-bit address / 32-bit data peripheral bus
interface multi_timer_if;
  logic [12:0] addr_bi;
  logic [31:0] data_bi;
  logic [31:0] data_bo;
  logic        rd_i;
  logic        wr_i;
  modport master (output addr_bi, data_bi, rd_i, wr_i, input data_bo);
  modport slave  (input addr_bi, data_bi, rd_i, wr_i, output data_bo);
endinterface

// File: rtl/multi_timer_channel.sv
// timer_channel: one up/down counter with period, config, sticky wrap flag.
// MULTI_TIMER_PRESCALE_EN adds an 8-bit prescaler in TCONF[15:8].
module timer_channel
  import multi_timer_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_i,
  input  ch_we_t           we_i,
  input  logic [31:0]      wdata_i,
  output logic [CNT_W-1:0] tmr_o,
  output logic [CNT_W-1:0] tval_o,
  output logic [15:0]      conf_o,
  output logic             wrap_o
);
`ifdef MULTI_TIMER_PRESCALE_EN
  localparam logic [15:0] CONF_MASK = 16'hFF0F;
`else
  localparam logic [15:0] CONF_MASK = 16'h000F;
`endif
  logic [CNT_W-1:0] tmr_q, tmr_d, tval_q, tval_d, tval_step;
  logic [15:0] conf_q, conf_d;
  logic wrap_q, wrap_d, tick, at_end, wrap_ev, unused_w;
  assign unused_w = ^wdata_i;
`ifdef MULTI_TIMER_PRESCALE_EN
  logic [7:0] psc_q, psc_d;
  assign tick  = conf_q[RUN_B] && psc_q == conf_q[PSC_MSB:PSC_LSB];
  assign psc_d = (!conf_q[RUN_B] || we_i.conf || tick) ? 8'd0 : psc_q + 8'd1;
  always_ff @(posedge clk or posedge rst_i)
    if (rst_i) psc_q <= '0;
    else psc_q <= psc_d;
`else
  assign tick = conf_q[RUN_B];
`endif
  assign at_end  = conf_q[DIR_B] ? tval_q == '0 : tval_q == tmr_q;
  assign wrap_ev = tick && at_end;
  always_comb begin
    tval_step = conf_q[DIR_B] ? (at_end ? tmr_q : tval_q - CNT_W'(1))
                              : (at_end ? '0 : tval_q + CNT_W'(1));
    tmr_d  = we_i.tmr ? wdata_i[CNT_W-1:0] : tmr_q;
    tval_d = we_i.tval ? wdata_i[CNT_W-1:0] : tick ? tval_step : tval_q;
    conf_d = we_i.conf ? (wdata_i[15:0] & CONF_MASK)
                       : (wrap_ev && conf_q[ONESHOT_B]) ? (conf_q & ~(16'd1 << RUN_B)) : conf_q;
    wrap_d = wrap_ev || (wrap_q && !(we_i.stat && wdata_i[0]));
  end
  always_ff @(posedge clk or posedge rst_i)
    if (rst_i) begin
      tmr_q  <= '0;
      tval_q <= '0;
      conf_q <= '0;
      wrap_q <= 1'b0;
    end else begin
      tmr_q  <= tmr_d;
      tval_q <= tval_d;
      conf_q <= conf_d;
      wrap_q <= wrap_d;
    end
  assign tmr_o  = tmr_q;
  assign tval_o = tval_q;
  assign conf_o = conf_q;
  assign wrap_o = wrap_q;
endmodule

// File: rtl/multi_timer.sv
// multi_timer: bank of CH_NUM memory-mapped timers with registered read data, values and irq.
// Optional prescaler via MULTI_TIMER_PRESCALE_EN (implemented in timer_channel).
module multi_timer
  import multi_timer_pkg::*;
#(
  parameter int CH_NUM = 4,
  parameter int CNT_W  = 16
) (
  input  logic                    clk,
  input  logic                    rst_i,
  multi_timer_if.slave            bus,
  output logic [CH_NUM*CNT_W-1:0] t_val_bo,
  output logic                    irq_o
);
  logic [7:0] ch;
  logic [3:0] rg;
  logic hit, irq_q;
  logic [31:0] rv [CH_NUM];
  logic [31:0] rd_all, rdata_q, rdata_d;
  logic [CH_NUM-1:0] irq_v;
  logic [CH_NUM*CNT_W-1:0] tval_all, tv_q;
  assign ch  = bus.addr_bi[CH_MSB:CH_LSB];
  assign rg  = bus.addr_bi[3:0];
  assign hit = !bus.addr_bi[12] && bus.addr_bi[1:0] == 2'b00 && 32'(ch) < CH_NUM;
  for (genvar k = 0; k < CH_NUM; k++) begin : g_ch
    logic [CNT_W-1:0] tmr, tval;
    logic [15:0] conf;
    logic wrap, sel;
    ch_we_t we;
    assign sel = hit && ch == 8'(k);
    assign we  = '{tmr:  bus.wr_i && sel && rg == TMR_OFS,
                   tval: bus.wr_i && sel && rg == TVAL_OFS,
                   conf: bus.wr_i && sel && rg == TCONF_OFS,
                   stat: bus.wr_i && sel && rg == TSTAT_OFS};
    timer_channel #(.CNT_W(CNT_W)) u_ch (
      .clk    (clk),
      .rst_i  (rst_i),
      .we_i   (we),
      .wdata_i(bus.data_bi),
      .tmr_o  (tmr),
      .tval_o (tval),
      .conf_o (conf),
      .wrap_o (wrap)
    );
    // hit already forces rg onto one of the four word offsets
    assign rv[k] = !sel ? 32'd0 : rg == TMR_OFS ? 32'(tmr) : rg == TVAL_OFS ? 32'(tval)
                 : rg == TCONF_OFS ? 32'(conf) : 32'(wrap);
    assign tval_all[k*CNT_W +: CNT_W] = tval;
    assign irq_v[k] = wrap && conf[IE_B];
  end
  always_comb begin
    rd_all = '0;
    for (int i = 0; i < CH_NUM; i++) rd_all = rd_all | rv[i];
    rdata_d = bus.rd_i ? rd_all : rdata_q;
  end
  always_ff @(posedge clk or posedge rst_i)
    if (rst_i) begin
      rdata_q <= '0;
      tv_q    <= '0;
      irq_q   <= 1'b0;
    end else begin
      rdata_q <= rdata_d;
      tv_q    <= tval_all;
      irq_q   <= |irq_v;
    end
  assign bus.data_bo = rdata_q;
  assign t_val_bo    = tv_q;
  assign irq_o       = irq_q;
endmodule
